// File: rtl/arm_ctrl_pkg.sv
// Shared types for the multicycle ARM-subset controller:
// FSM states, opcode/ALU constants and condition evaluation.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL
  } cond_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Cond 1111 is reserved and falls into the default (false).
  function automatic logic cond_eval(
    input logic [3:0] cond,
    input logic [3:0] nzcv
  );
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond)
      EQ:      r = z;
      NE:      r = ~z;
      CS:      r = c;
      CC:      r = ~c;
      MI:      r = n;
      PL:      r = ~n;
      VS:      r = v;
      VC:      r = ~v;
      HI:      r = c & ~z;
      LS:      r = ~c | z;
      GE:      r = (n == v);
      LT:      r = (n != v);
      GT:      r = ~z & (n == v);
      LE:      r = z | (n != v);
      AL:      r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arm_multicycle_controller_cond_unit.sv
// Architectural NZCV register, its write enables and the
// condition-pass signal derived from the registered flags.
module cond_unit
  import arm_ctrl_pkg::*;
#(
  parameter bit FULL_COND = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_req_i,
  input  logic       cv_req_i,
  output logic [3:0] flags_o,
  output logic       cond_ex_o
);

  logic [3:0] flags_q, flags_d;

  always_comb begin
    cond_ex_o = 1'b0;
    if (FULL_COND) begin
      cond_ex_o = cond_eval(cond_i, flags_q);
    end else begin
      case (cond_i)
        EQ:      cond_ex_o = flags_q[2];
        NE:      cond_ex_o = ~flags_q[2];
        AL:      cond_ex_o = 1'b1;
        default: cond_ex_o = 1'b0;
      endcase
    end
  end

  // NZ follow every flag-setting op; CV only arithmetic ones.
  always_comb begin
    flags_d = flags_q;
    if (flag_req_i && cond_ex_o) begin
      flags_d[3:2] = alu_flags_i[3:2];
      if (cv_req_i) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/arm_multicycle_controller.sv
// Multicycle control FSM for the ARM-subset core: sequences
// fetch/decode/execute/memory/writeback and drives datapath enables.
module arm_multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 2,
  parameter bit FULL_COND = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic [3:0]           State
);

  state_t state_q, state_d;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       unused_bits;

  assign op          = Instr[27:26];
  assign funct       = Instr[25:20];
  assign cmd         = funct[4:1];
  assign rd          = Instr[15:12];
  assign unused_bits = ^{Instr[19:16], Instr[11:0]};

  logic [ALUCTRL_W-1:0] dp_op, alu_op;
  logic dp_valid, dp_arith, no_write;

  always_comb begin
    dp_op    = ALUCTRL_W'(ALU_ADD);
    dp_valid = 1'b1;
    dp_arith = 1'b0;
    no_write = 1'b0;
    case (cmd)
      CMD_ADD: dp_arith = 1'b1;
      CMD_SUB: begin
        dp_op    = ALUCTRL_W'(ALU_SUB);
        dp_arith = 1'b1;
      end
      CMD_CMP: begin
        dp_op    = ALUCTRL_W'(ALU_SUB);
        dp_arith = 1'b1;
        no_write = 1'b1;
      end
      CMD_AND: dp_op = ALUCTRL_W'(ALU_AND);
      CMD_ORR: dp_op = ALUCTRL_W'(ALU_ORR);
      CMD_EOR: begin
        if (ALUCTRL_W >= 3) dp_op = ALUCTRL_W'(ALU_EOR);
        else                dp_valid = 1'b0;
      end
      default: dp_valid = 1'b0;
    endcase
  end

  logic pcw, memw, irw, regw, flag_req, cond_ex;

  // Defaults are the FETCH values so reset leaves them in place.
  always_comb begin
    state_d   = state_q;
    pcw       = 1'b0;
    memw      = 1'b0;
    irw       = 1'b0;
    regw      = 1'b0;
    flag_req  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b1;
    ALUSrcB   = 2'b10;
    ResultSrc = 2'b10;
    alu_op    = ALUCTRL_W'(ALU_ADD);
    case (state_q)
      S_FETCH: begin
        if (MemReady) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b01;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b01;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw      = cond_ex;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b01;
        memw    = cond_ex;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA  = 1'b0;
        ALUSrcB  = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_op   = dp_op;
        flag_req = dp_valid & funct[0];
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        regw      = cond_ex & ~no_write;
        pcw       = cond_ex & ~no_write & (rd == 4'hF);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB = 2'b01;
        pcw     = cond_ex;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  cond_unit #(
    .FULL_COND(FULL_COND)
  ) u_cond (
    .clk_i      (clk),
    .rst_i      (rst),
    .cond_i     (Instr[31:28]),
    .alu_flags_i(ALUFlags),
    .flag_req_i (flag_req),
    .cv_req_i   (dp_arith),
    .flags_o    (Flags),
    .cond_ex_o  (cond_ex)
  );

  // Enables are masked during reset even though state is FETCH.
  assign PCWrite    = pcw & ~rst;
  assign MemWrite   = memw & ~rst;
  assign IRWrite    = irw & ~rst;
  assign RegWrite   = regw & ~rst;
  assign ALUControl = alu_op;
  assign ImmSrc     = (op == OP_NOP) ? 2'b00 : op;
  assign RegSrc     = {op == OP_MEM, op == OP_BR};
  assign State      = state_q;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Scoreboard bench: instruction-level schedule model predicts every
// cycle's outputs for a 2-bit and a 3-bit ALUControl build.
module tb_arm_multicycle_controller;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_MEMADR = 2;
  localparam int P_MEMRD  = 3;
  localparam int P_MEMWB  = 4;
  localparam int P_MEMWR  = 5;
  localparam int P_EXECR  = 6;
  localparam int P_EXECI  = 7;
  localparam int P_ALUWB  = 8;
  localparam int P_BRANCH = 9;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] rs;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] imm;
    logic [1:0] rgs;
    logic       regw;
    logic [2:0] alu;
    logic [3:0] fl;
  } exp_t;

  typedef struct packed {
    exp_t e2;
    exp_t m2;
    exp_t e3;
    exp_t m3;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        MemReady = 1'b0;

  logic       pcw2, adr2, memw2, irw2, asa2, regw2;
  logic [1:0] rs2, asb2, imm2, rgs2, alu2;
  logic [3:0] fl2, st2;
  logic       pcw3, adr3, memw3, irw3, asa3, regw3;
  logic [1:0] rs3, asb3, imm3, rgs3;
  logic [2:0] alu3;
  logic [3:0] fl3, st3;

  always #5 clk = ~clk;

  arm_multicycle_controller #(.ALUCTRL_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .Instr(Instr),
    .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(memw2),
    .IRWrite(irw2), .ResultSrc(rs2), .ALUSrcA(asa2),
    .ALUSrcB(asb2), .ImmSrc(imm2), .RegSrc(rgs2),
    .RegWrite(regw2), .ALUControl(alu2),
    .Flags(fl2), .State(st2)
  );

  arm_multicycle_controller #(.ALUCTRL_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .Instr(Instr),
    .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(pcw3), .AdrSrc(adr3), .MemWrite(memw3),
    .IRWrite(irw3), .ResultSrc(rs3), .ALUSrcA(asa3),
    .ALUSrcB(asb3), .ImmSrc(imm3), .RegSrc(rgs3),
    .RegWrite(regw3), .ALUControl(alu3),
    .Flags(fl3), .State(st3)
  );

  sb_t        q[$];
  int         n_push = 0;
  int         n_pop = 0;
  int         tests = 0;
  int         fails = 0;
  bit         done = 1'b0;
  logic [3:0] mf2 = 4'h0;
  logic [3:0] mf3 = 4'h0;

  function automatic logic cond_true(
    input logic [3:0] c, input logic [3:0] f
  );
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(
    input logic [3:0] cmd, input bit w3
  );
    case (cmd)
      4'b0100: return 3'd0;
      4'b0010: return 3'd1;
      4'b1010: return 3'd1;
      4'b0000: return 3'd2;
      4'b1100: return 3'd3;
      4'b0001: return w3 ? 3'd4 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit known_op(
    input logic [3:0] cmd, input bit w3
  );
    case (cmd)
      4'b0100, 4'b0010, 4'b1010,
      4'b0000, 4'b1100: return 1'b1;
      4'b0001: return w3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void build(
    input int ph, input logic mr, input logic r,
    input logic [31:0] ins, input logic [3:0] fl,
    input bit w3, output exp_t e, output exp_t m
  );
    logic [1:0] op;
    logic [3:0] cmd;
    logic       c, wr;
    int         p;
    op  = ins[27:26];
    cmd = ins[24:21];
    c   = cond_true(ins[31:28], fl);
    p   = r ? P_FETCH : ph;
    e = '0;
    m = '0;
    e.st = 4'(p);
    m.st = '1;
    m.pcw = 1'b1;
    m.memw = 1'b1;
    m.irw = 1'b1;
    m.regw = 1'b1;
    e.fl = r ? 4'h0 : fl;
    m.fl = '1;
    e.rgs = {op == 2'b01, op == 2'b10};
    m.rgs = '1;
    if (op != 2'b11) begin
      e.imm = op;
      m.imm = '1;
    end
    case (p)
      P_FETCH: begin
        e.asa = 1'b1; m.asa = 1'b1;
        e.asb = 2'b10; m.asb = '1;
        e.rs = 2'b10; m.rs = '1;
        m.adr = 1'b1; m.alu = '1;
        e.irw = mr & !r;
        e.pcw = mr & !r;
      end
      P_DECODE: begin
        e.asa = 1'b1; m.asa = 1'b1;
        e.asb = 2'b10; m.asb = '1;
        e.rs = 2'b10; m.rs = '1;
        m.alu = '1;
      end
      P_MEMADR: begin
        e.asb = 2'b01; m.asb = '1;
        m.alu = '1;
      end
      P_MEMRD: begin
        e.adr = 1'b1; m.adr = 1'b1;
      end
      P_MEMWB: begin
        e.rs = 2'b01; m.rs = '1;
        e.regw = c;
      end
      P_MEMWR: begin
        e.adr = 1'b1; m.adr = 1'b1;
        e.memw = c;
      end
      P_EXECR, P_EXECI: begin
        e.asb = (p == P_EXECI) ? 2'b01 : 2'b00;
        m.asb = '1;
        e.alu = alu_of(cmd, w3);
        m.alu = '1;
      end
      P_ALUWB: begin
        wr = c && (cmd != 4'b1010);
        e.rs = 2'b00; m.rs = '1;
        e.regw = wr;
        e.pcw = wr && (ins[15:12] == 4'hF);
      end
      P_BRANCH: begin
        e.asb = 2'b01; m.asb = '1;
        e.rs = 2'b10; m.rs = '1;
        e.pcw = c;
      end
      default: ;
    endcase
  endfunction

  task automatic upd(
    input logic [31:0] ins, input logic [3:0] af,
    input bit w3, inout logic [3:0] fl
  );
    logic [3:0] cmd;
    cmd = ins[24:21];
    if (ins[20] && known_op(cmd, w3) &&
        cond_true(ins[31:28], fl)) begin
      fl[3:2] = af[3:2];
      if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)
        fl[1:0] = af[1:0];
    end
  endtask

  task automatic step(
    input int ph, input logic mr, input logic r,
    input logic [31:0] ins, input logic [3:0] af
  );
    sb_t s;
    exp_t e, m;
    rst = r;
    Instr = ins;
    ALUFlags = af;
    MemReady = mr;
    build(ph, mr, r, ins, mf2, 1'b0, e, m);
    s.e2 = e;
    s.m2 = m;
    build(ph, mr, r, ins, mf3, 1'b1, e, m);
    s.e3 = e;
    s.m3 = m;
    q.push_back(s);
    n_push++;
    if (r) begin
      mf2 = 4'h0;
      mf3 = 4'h0;
    end else if (ph == P_EXECR || ph == P_EXECI) begin
      upd(ins, af, 1'b0, mf2);
      upd(ins, af, 1'b1, mf3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(
    input logic [31:0] ins, input int fw,
    input int mw, input logic [3:0] xaf
  );
    for (int i = 0; i < fw; i++)
      step(P_FETCH, 1'b0, 1'b0, $urandom, 4'($urandom));
    step(P_FETCH, 1'b1, 1'b0, $urandom, 4'($urandom));
    step(P_DECODE, 1'($urandom), 1'b0, ins, 4'($urandom));
    case (ins[27:26])
      2'b01: begin
        step(P_MEMADR, 1'($urandom), 1'b0, ins, 4'($urandom));
        if (ins[20]) begin
          for (int i = 0; i < mw; i++)
            step(P_MEMRD, 1'b0, 1'b0, ins, 4'($urandom));
          step(P_MEMRD, 1'b1, 1'b0, ins, 4'($urandom));
          step(P_MEMWB, 1'($urandom), 1'b0, ins, 4'($urandom));
        end else begin
          for (int i = 0; i < mw; i++)
            step(P_MEMWR, 1'b0, 1'b0, ins, 4'($urandom));
          step(P_MEMWR, 1'b1, 1'b0, ins, 4'($urandom));
        end
      end
      2'b10: step(P_BRANCH, 1'($urandom), 1'b0, ins, 4'($urandom));
      2'b00: begin
        step(ins[25] ? P_EXECI : P_EXECR, 1'($urandom),
             1'b0, ins, xaf);
        step(P_ALUWB, 1'($urandom), 1'b0, ins, 4'($urandom));
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] c, cmd, rd;
    logic [1:0] op;
    logic [5:0] fn;
    c  = ($urandom % 6 == 0) ? 4'($urandom) : 4'hE;
    op = 2'($urandom);
    fn = 6'($urandom);
    case ($urandom % 8)
      0: cmd = 4'b0100;
      1: cmd = 4'b0010;
      2: cmd = 4'b1010;
      3: cmd = 4'b0000;
      4: cmd = 4'b1100;
      5: cmd = 4'b0001;
      default: cmd = 4'($urandom);
    endcase
    if (op == 2'b00) fn[4:1] = cmd;
    if (op == 2'b00 && cmd == 4'b1010) fn[0] = 1'b1;
    rd = ($urandom % 5 == 0) ? 4'hF : 4'($urandom);
    return {c, op, fn, 4'($urandom), rd, 12'($urandom)};
  endfunction

  exp_t a2, a3;
  sb_t  cur;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      n_pop++;
      a2 = {st2, pcw2, adr2, memw2, irw2, rs2, asa2,
            asb2, imm2, rgs2, regw2, {1'b0, alu2}, fl2};
      a3 = {st3, pcw3, adr3, memw3, irw3, rs3, asa3,
            asb3, imm3, rgs3, regw3, alu3, fl3};
      tests++;
      if ((a2 & cur.m2) !== (cur.e2 & cur.m2)) begin
        fails++;
        $display("FAIL w2 cyc%0d got=%h exp=%h mask=%h",
                 n_pop, a2, cur.e2, cur.m2);
      end
      tests++;
      if ((a3 & cur.m3) !== (cur.e3 & cur.m3)) begin
        fails++;
        $display("FAIL w3 cyc%0d got=%h exp=%h mask=%h",
                 n_pop, a3, cur.e3, cur.m3);
      end
    end else if (done) begin
      tests++;
      if (n_pop != n_push) begin
        fails++;
        $display("FAIL drain got=%0d need=%0d", n_pop, n_push);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    step(P_FETCH, 1'b1, 1'b1, 32'hE2811005, 4'h0);
    run(32'hE2811005, 0, 0, 4'hF);
    run(32'hE2500000, 1, 0, 4'b0100);
    run(32'h0A000002, 0, 0, 4'h0);
    run(32'h1A000002, 0, 0, 4'h0);
    run(32'hE5910000, 0, 3, 4'h0);
    run(32'hE3500000, 0, 0, 4'b1000);
    run(32'hBA000000, 0, 0, 4'h0);
    run(32'hE0311002, 0, 0, 4'b1011);
    step(P_FETCH, 1'b1, 1'b0, 32'hE5810000, 4'h0);
    step(P_DECODE, 1'b1, 1'b0, 32'hE5810000, 4'h0);
    step(P_MEMADR, 1'b1, 1'b0, 32'hE5810000, 4'h0);
    step(P_MEMWR, 1'b0, 1'b0, 32'hE5810000, 4'h0);
    step(P_MEMWR, 1'b0, 1'b0, 32'hE5810000, 4'h0);
    step(P_MEMWR, 1'b1, 1'b1, 32'hE5810000, 4'h0);
    for (int n = 0; n < 400; n++)
      run(rand_instr(), $urandom % 3, $urandom % 4,
          4'($urandom));
    done = 1'b1;
  end

endmodule
